// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// It also drains pending writebacks before raising a sticky halt.
module regs_wb_arbiter #(
  parameter int NREQ     = 2,
  parameter int AW       = 5,
  parameter int DW       = 64,
  parameter int HALT_GAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               halt_req,
  output logic               wen,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic               halt,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (HALT_GAP > 1) ? $clog2(HALT_GAP + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            halt_q, halt_d;

  logic [NREQ-1:0] grant_s;
  logic [PW-1:0]   gidx_s;
  logic [PW-1:0]   idx_s;
  logic            gnt_any_s;

  // Search starts at rr_ptr and wraps; grants are gated off during reset.
  always_comb begin
    grant_s   = '0;
    gidx_s    = '0;
    idx_s     = '0;
    gnt_any_s = 1'b0;
    if (rst_n && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = PW'((int'(rr_ptr_q) + k) % NREQ);
        if (!gnt_any_s && req_valid[idx_s]) begin
          grant_s[idx_s] = 1'b1;
          gidx_s         = idx_s;
          gnt_any_s      = 1'b1;
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  always_comb begin
    wen_d    = gnt_any_s;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_any_s) begin
      rr_ptr_d = (gidx_s == PW'(NREQ - 1)) ? '0 : gidx_s + PW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        waddr_d = req_addr[i*AW +: AW];
        wdata_d = req_data[i*DW +: DW];
      end else begin
        waddr_d = waddr_d;
      end
    end
  end

  // Halt sequencing: drain requesters, then wait HALT_GAP idle write cycles.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (req_valid == '0) begin
          state_d   = ST_FLUSH;
          gap_cnt_d = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (!wen_q) begin
          if (gap_cnt_q == GW'(HALT_GAP - 1)) begin
            state_d = ST_HALT;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end else begin
          gap_cnt_d = '0;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d   = ST_RUN;
        gap_cnt_d = '0;
      end
    endcase
    halt_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      halt_q    <= halt_d;
    end
  end

  assign req_ready = grant_s;
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign halt      = halt_q;
  assign busy      = (state_q != ST_RUN) || wen_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Randomized self-checking bench for regs_wb_arbiter against a transaction-level
// model: pending requests per requester, a rotating priority index, and a halt countdown.
module tb_regs_wb_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int HG   = 1;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               halt_req;
  logic               wen;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               halt;
  logic               busy;

  int checks = 0;
  int passed = 0;

  bit          p_v[NREQ];
  logic [AW-1:0] p_a[NREQ];
  logic [DW-1:0] p_d[NREQ];
  logic [DW-1:0] m_rf[32];
  logic [DW-1:0] d_rf[32];
  int  m_rr;
  bit  m_accept;
  bit  m_drain;
  int  m_halt_in;
  bit  m_halted;

  regs_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .HALT_GAP(HG)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .halt_req(halt_req),
    .wen(wen), .waddr(waddr), .wdata(wdata), .halt(halt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  function automatic int exp_grant();
    if (!m_accept) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_rr + k) % NREQ;
      if (p_v[j]) return j;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_rr = 0; m_accept = 1'b1; m_drain = 1'b0; m_halt_in = 0; m_halted = 1'b0;
    for (int i = 0; i < NREQ; i++) p_v[i] = 1'b0;
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end
  endtask

  // One clock: drive pending requests, check the grant, then the registered write.
  task automatic do_cycle(input logic hreq, output int g);
    logic [NREQ-1:0] eg;
    bit none;
    none = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = p_v[i];
      req_addr[i*AW +: AW] = p_a[i];
      req_data[i*DW +: DW] = p_d[i];
      if (p_v[i]) none = 1'b0;
    end
    halt_req = hreq;
    #1;
    g = exp_grant();
    eg = (g < 0) ? '0 : (NREQ'(1) << g);
    checks++;
    if (req_ready !== eg) $display("FAIL grant: req_ready=%b expected %b at %0t", req_ready, eg, $time);
    else passed++;
    @(posedge clk);
    #1;
    halt_req = 1'b0;
    if (g >= 0) begin
      m_rf[p_a[g]] = p_d[g];
      m_rr = (g + 1) % NREQ;
      p_v[g] = 1'b0;
    end
    if (m_halt_in > 0) begin
      m_halt_in--;
      if (m_halt_in == 0) m_halted = 1'b1;
    end
    if (!m_drain && m_accept && hreq) m_drain = 1'b1;
    else if (m_drain && none) begin
      m_drain = 1'b0; m_accept = 1'b0; m_halt_in = HG;
    end
    checks++;
    if (wen !== (g >= 0)) $display("FAIL wen: wen=%b expected %b at %0t", wen, (g >= 0), $time);
    else passed++;
    if (g >= 0) begin
      checks++;
      if ({waddr, wdata} !== {p_a[g], p_d[g]})
        $display("FAIL wdata: addr=%0d data=%h expected addr=%0d data=%h", waddr, wdata, p_a[g], p_d[g]);
      else passed++;
    end
    checks++;
    if ({halt, busy} !== {m_halted, (m_drain || !m_accept || (g >= 0))})
      $display("FAIL halt_busy: halt=%b busy=%b expected halt=%b busy=%b at %0t", halt, busy,
               m_halted, (m_drain || !m_accept || (g >= 0)), $time);
    else passed++;
    if (wen === 1'b1) d_rf[waddr] = wdata;
  endtask

  task automatic check_rf(input string tag);
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (d_rf[r] !== m_rf[r]) $display("FAIL %s rf[%0d]: got %h expected %h", tag, r, d_rf[r], m_rf[r]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    int g;
    rst_n = 1'b0;
    req_valid = 2'b11;
    halt_req = 1'b1;
    #1;
    checks++;
    if ({req_ready, wen, waddr, wdata, halt, busy} !== {2'b00, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0})
      $display("FAIL reset: ready=%b wen=%b waddr=%0d wdata=%h halt=%b busy=%b expected all 0",
               req_ready, wen, waddr, wdata, halt, busy);
    else passed++;
    apply_reset();
    do_cycle(1'b0, g);
  endtask

  task automatic test_single();
    int g;
    apply_reset();
    p_v[0] = 1'b1; p_a[0] = 5'd3; p_d[0] = 64'hAA;
    do_cycle(1'b0, g);
    do_cycle(1'b0, g);
  endtask

  task automatic test_back_to_back();
    int g;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        p_v[i] = 1'b1; p_a[i] = AW'(i + 1); p_d[i] = DW'(i);
      end
      do_cycle(1'b0, g);
      checks++;
      if (g !== (c % 2)) $display("FAIL b2b_order: granted %0d expected %0d", g, c % 2);
      else passed++;
    end
    for (int i = 0; i < NREQ; i++) p_v[i] = 1'b0;
    do_cycle(1'b0, g);
  endtask

  task automatic test_same_addr();
    int g;
    apply_reset();
    p_v[1] = 1'b1; p_a[1] = 5'd7; p_d[1] = 64'd5;
    do_cycle(1'b0, g);
    p_v[0] = 1'b1; p_a[0] = 5'd7; p_d[0] = 64'd9;
    do_cycle(1'b0, g);
    do_cycle(1'b0, g);
    checks++;
    if (d_rf[7] !== 64'd9) $display("FAIL same_addr: r7=%h expected %h", d_rf[7], 64'd9);
    else passed++;
  endtask

  task automatic test_random();
    int g;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_v[i] && ($urandom_range(0, 99) < 60)) begin
          p_v[i] = 1'b1;
          p_a[i] = AW'($urandom_range(0, 7));
          p_d[i] = {$urandom, $urandom};
        end
      end
      do_cycle(1'b0, g);
    end
    for (int c = 0; c < 4; c++) do_cycle(1'b0, g);
    check_rf("random");
  endtask

  task automatic test_halt_with_req();
    int g;
    apply_reset();
    p_v[1] = 1'b1; p_a[1] = 5'd4; p_d[1] = 64'h77;
    do_cycle(1'b1, g);
    do_cycle(1'b0, g);
    for (int i = 0; i < NREQ; i++) begin p_v[i] = 1'b1; p_a[i] = 5'd1; p_d[i] = 64'h1; end
    do_cycle(1'b0, g);
    checks++;
    if (halt !== 1'b1) $display("FAIL halt_req_t3: halt=%b expected 1", halt);
    else passed++;
    do_cycle(1'b1, g);
  endtask

  task automatic test_halt_idle();
    int g;
    apply_reset();
    do_cycle(1'b1, g);
    do_cycle(1'b0, g);
    do_cycle(1'b0, g);
    for (int i = 0; i < NREQ; i++) begin p_v[i] = 1'b1; p_a[i] = 5'd2; p_d[i] = 64'h3; end
    for (int c = 0; c < 3; c++) do_cycle(1'b1, g);
  endtask

  task automatic test_drain_random();
    int g;
    int n;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_v[i] && ($urandom_range(0, 99) < 70)) begin
          p_v[i] = 1'b1; p_a[i] = AW'($urandom_range(0, 31)); p_d[i] = {$urandom, $urandom};
        end
      end
      do_cycle(1'b0, g);
    end
    for (int i = 0; i < NREQ; i++) begin
      p_v[i] = 1'b1; p_a[i] = AW'($urandom_range(0, 31)); p_d[i] = {$urandom, $urandom};
    end
    do_cycle(1'b1, g);
    n = 0;
    while (!m_halted && n < 50) begin
      do_cycle(1'(($urandom_range(0, 1))), g);
      n++;
    end
    checks++;
    if (halt !== 1'b1) $display("FAIL drain_halt: halt=%b expected 1 within budget", halt);
    else passed++;
    check_rf("drain");
  endtask

  task automatic test_reset_mid_drain();
    int g;
    apply_reset();
    p_v[0] = 1'b1; p_a[0] = 5'd9; p_d[0] = 64'hDEAD;
    do_cycle(1'b1, g);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if ({req_ready, wen, waddr, wdata, halt, busy} !== {2'b00, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0})
      $display("FAIL mid_reset: ready=%b wen=%b waddr=%0d wdata=%h halt=%b busy=%b expected all 0",
               req_ready, wen, waddr, wdata, halt, busy);
    else passed++;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin p_v[i] = 1'b1; p_a[i] = AW'(i + 10); p_d[i] = DW'(i + 100); end
    do_cycle(1'b0, g);
    checks++;
    if (g !== 0) $display("FAIL post_reset_rr: granted %0d expected 0", g);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    halt_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin p_v[i] = 1'b0; p_a[i] = '0; p_d[i] = '0; end
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_same_addr();
    test_random();
    test_halt_with_req();
    test_halt_idle();
    test_drain_random();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
